fp_mul_arbiter: RTL and testbench

//  Shares one pipelined IEEE-754 single-precision multiplier between NREQ requesters
//  (the radix-6 butterfly twiddle/constant multiply ports) using round-robin arbitration.

---
 rtl/fp_mul_arbiter.sv | 144 ++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined FP32 multiplier among NREQ
// requesters. A tag pipeline tracks each issued operand pair so that every product
// is routed back to its owner as a one-cycle pulse.
// Optional feature macro: FP_MUL_ARB_PERF_EN adds perf_busy / perf_stall counters.
module fp_mul_arbiter #(
  parameter int unsigned NREQ    = 6,
  parameter int unsigned IDW     = 3,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_c,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
`ifdef FP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall
`endif
);

  // One tag stage per multiplier edge plus the stage that lines up with mul_c.
  localparam int unsigned DEPTH = MUL_LAT + 1;
  localparam int unsigned DW    = 32;

  logic [IDW-1:0]            ptr;
  logic [IDW-1:0]            gnt_idx;
  logic                      gnt_found;
  logic                      hs;
  int unsigned               cand;
  logic [DW-1:0]             sel_a;
  logic [DW-1:0]             sel_b;
  logic [DEPTH-1:0]          tag_vld;
  logic [DEPTH-1:0][IDW-1:0] tag_id;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
    req_ready = '0;
    if (!rst && en && !flush && gnt_found) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
    hs = |(req_valid & req_ready);
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[DW*i +: DW];
        sel_b = req_b[DW*i +: DW];
      end
    end
  end

  // Operand issue register and round-robin pointer; both move only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      ptr   <= IDW'(NREQ - 1);
    end else if (hs) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
      ptr   <= gnt_idx;
    end
  end

  // Tag pipeline: bubbles enter when nothing is issued; flush kills every tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_id <= {tag_id[DEPTH-2:0], gnt_idx};
      if (flush) begin
        tag_vld <= '0;
      end else begin
        tag_vld <= {tag_vld[DEPTH-2:0], hs};
      end
    end
  end

  // Return path: capture the product whose tag reaches the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      if (!flush && tag_vld[DEPTH-1]) begin
        rsp_valid <= NREQ'(1) << tag_id[DEPTH-1];
        rsp_data  <= mul_c;
        rsp_id    <= tag_id[DEPTH-1];
      end
    end
  end

`ifdef FP_MUL_ARB_PERF_EN
  logic stall_c;

  // A cycle stalls when grants are enabled but some valid request is not granted.
  always_comb begin
    stall_c = en && (|(req_valid & ~req_ready));
  end

  // Saturating activity counters; flush does not touch them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (hs && (perf_busy != 32'hFFFF_FFFF)) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (stall_c && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural MUL_LAT-deep multiplier.
// Define FP_MUL_ARB_PERF_EN to also check the perf counters.
module tb_fp_mul_arbiter;

  localparam int unsigned NREQ    = 6;
  localparam int unsigned IDW     = 3;
  localparam int unsigned MUL_LAT = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               flush;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_c;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0]        perf_busy;
  logic [31:0]        perf_stall;
`endif

  fp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef FP_MUL_ARB_PERF_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: exact products for the known FP vectors, XOR otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4000_0000;
    if (a == 32'h4040_0000 && b == 32'h4080_0000) return 32'h4140_0000;
    return a ^ b;
  endfunction

  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_c = mpipe[MUL_LAT-1];

  function automatic logic [31:0] opa(input int i);
    return 32'(32'h1111_1111 * (i + 1));
  endfunction
  function automatic logic [31:0] opb(input int i);
    return 32'(32'h0000_00F0 | i);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              c;
    logic [NREQ-1:0] vld;
    logic [IDW-1:0]  id;
    logic [31:0]     data;
  } rsp_t;
  rsp_t rq[$];

  // Response log, sampled 1 time unit after each rising edge.
  always begin
    rsp_t r;
    @(posedge clk);
    #1;
    if (rsp_valid != '0) begin
      r.c = cyc; r.vld = rsp_valid; r.id = rsp_id; r.data = rsp_data;
      rq.push_back(r);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_ops();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[32*i +: 32] = opa(i);
      req_b[32*i +: 32] = opb(i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic expect_rsp(input string tag, input int k, input int c, input int id,
                            input logic [31:0] d);
    if (k >= rq.size()) begin
      check({tag, " present"}, 32'(rq.size()), 32'(k + 1));
    end else begin
      check({tag, " cycle"}, 32'(rq[k].c), 32'(c));
      check({tag, " valid"}, 32'(rq[k].vld), 32'(NREQ'(1) << id));
      check({tag, " id"},    32'(rq[k].id), 32'(id));
      check({tag, " data"},  rq[k].data, d);
    end
  endtask

  int hs0;

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; req_valid = '0;
    load_ops();
    #3;
    check("reset mul_a",     mul_a, 32'h0);
    check("reset mul_b",     mul_b, 32'h0);
    check("reset rsp_data",  rsp_data, 32'h0);
    check("reset rsp_id",    32'(rsp_id), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    step(); step();
    rst = 1'b0;
    step();
    check("idle ready", 32'(req_ready), 32'h0);

    // 1: single request from requester 2, 1.0 * 2.0
    req_a[64 +: 32] = 32'h3F80_0000;
    req_b[64 +: 32] = 32'h4000_0000;
    req_valid = 6'b000100;
    #1;
    check("t1 ready", 32'(req_ready), 32'(6'b000100));
    hs0 = cyc + 1;
    step();
    req_valid = '0;
    check("t1 mul_a", mul_a, 32'h3F80_0000);
    check("t1 mul_b", mul_b, 32'h4000_0000);
    wait_n(10);
    check("t1 count", 32'(rq.size()), 32'd1);
    expect_rsp("t1", 0, hs0 + 6, 2, 32'h4000_0000);
    rq.delete();

    // 2: all requesters valid for 12 cycles after reset
    do_reset();
    load_ops();
    for (int k = 0; k < 12; k++) begin
      req_valid = '1;
      #1;
      check($sformatf("t2 grant %0d", k), 32'(req_ready), 32'(NREQ'(1) << (k % 6)));
      if (k == 0) hs0 = cyc + 1;
      step();
    end
    req_valid = '0;
    wait_n(10);
    check("t2 count", 32'(rq.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      expect_rsp($sformatf("t2 rsp %0d", k), k, hs0 + 6 + k, k % 6, opa(k % 6) ^ opb(k % 6));
`ifdef FP_MUL_ARB_PERF_EN
    check("t2 perf_busy",  perf_busy, 32'd12);
    check("t2 perf_stall", perf_stall, 32'd12);
`endif
    rq.delete();

    // 3: requester 0 back-to-back for 10 cycles, 3.0 * 4.0
    req_a[0 +: 32] = 32'h4040_0000;
    req_b[0 +: 32] = 32'h4080_0000;
    for (int k = 0; k < 10; k++) begin
      req_valid = 6'b000001;
      #1;
      check($sformatf("t3 ready %0d", k), 32'(req_ready), 32'(6'b000001));
      if (k == 0) hs0 = cyc + 1;
      step();
    end
    req_valid = '0;
    wait_n(10);
    check("t3 count", 32'(rq.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      expect_rsp($sformatf("t3 rsp %0d", k), k, hs0 + 6 + k, 0, 32'h4140_0000);
    rq.delete();

    // 4: three issues, flush two cycles after the last, then a fresh issue
    load_ops();
    for (int k = 0; k < 3; k++) begin
      req_valid = 6'b000010;
      #1;
      check($sformatf("t4 ready %0d", k), 32'(req_ready), 32'(6'b000010));
      step();
    end
    req_valid = '0;
    step();
    flush = 1'b1;
    req_valid = 6'b000010;
    #1;
    check("t4 flush ready", 32'(req_ready), 32'h0);
    step();
    flush = 1'b0;
    req_a[32 +: 32] = 32'h3F80_0000;
    req_b[32 +: 32] = 32'h4000_0000;
    #1;
    check("t4 post ready", 32'(req_ready), 32'(6'b000010));
    hs0 = cyc + 1;
    step();
    req_valid = '0;
    wait_n(12);
    check("t4 count", 32'(rq.size()), 32'd1);
    expect_rsp("t4", 0, hs0 + 6, 1, 32'h4000_0000);
    rq.delete();

    // 5: drop en with four products in flight, requests held valid
    load_ops();
    for (int k = 0; k < 4; k++) begin
      req_valid = 6'b011000;
      #1;
      check($sformatf("t5 grant %0d", k), 32'(req_ready), 32'(NREQ'(1) << (3 + (k % 2))));
      if (k == 0) hs0 = cyc + 1;
      step();
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 0 || k == 9) check($sformatf("t5 en0 ready %0d", k), 32'(req_ready), 32'h0);
      step();
    end
    req_valid = '0;
    en = 1'b1;
    check("t5 count", 32'(rq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      expect_rsp($sformatf("t5 rsp %0d", k), k, hs0 + 6 + k, 3 + (k % 2),
                 opa(3 + (k % 2)) ^ opb(3 + (k % 2)));
    rq.delete();

    // 6: asynchronous reset in the middle of a stream
    req_valid = 6'b100100;
    wait_n(8);
    rst = 1'b1;
    #1;
    check("t6 mul_a",     mul_a, 32'h0);
    check("t6 mul_b",     mul_b, 32'h0);
    check("t6 rsp_data",  rsp_data, 32'h0);
    check("t6 rsp_id",    32'(rsp_id), 32'h0);
    check("t6 rsp_valid", 32'(rsp_valid), 32'h0);
    check("t6 rst ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("t6 first grant", 32'(req_ready), 32'(6'b000100));
    step();
    req_valid = '0;
    wait_n(10);
    rq.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
